// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multi-cycle
// MUL/DIV unit that owns HI/LO.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO owner.
// Radix-2 shift-add multiply, restoring divide, one bit per cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             isdiv_q, isdiv_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acch_q, acch_d;
  logic [WIDTH-1:0] accl_q, accl_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sgn, a_neg, b_neg, is_md;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shl, dif;
  logic             ge;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    is_md = (bus.op[2] == 1'b0);
    sgn   = ~bus.op[0];
    a_neg = sgn & bus.a[WIDTH-1];
    b_neg = sgn & bus.b[WIDTH-1];
    a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;
  end

  // One iteration of both datapaths; isdiv_q picks.
  always_comb begin
    sum = {1'b0, acch_q}
        + {1'b0, (accl_q[0] ? m_q : '0)};
    shl = {acch_q, accl_q[WIDTH-1]};
    dif = shl - {1'b0, m_q};
    ge  = ~dif[WIDTH];
    if (isdiv_q) begin
      it_hi = ge ? dif[WIDTH-1:0]
                 : shl[WIDTH-1:0];
      it_lo = {accl_q[WIDTH-2:0], ge};
    end else begin
      it_hi = sum[WIDTH:1];
      it_lo = {sum[0], accl_q[WIDTH-1:1]};
    end
    prod   = {it_hi, it_lo};
    prod_f = neg_q ? (~prod + 1'b1) : prod;
    quo    = neg_q ? (~it_lo + 1'b1) : it_lo;
    rem    = rneg_q ? (~it_hi + 1'b1) : it_hi;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isdiv_d = isdiv_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    m_d     = m_q;
    acch_d  = acch_q;
    accl_d  = accl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          unique case (1'b1)
            is_md: begin
              state_d = S_BUSY;
              cnt_d   = '0;
              isdiv_d = bus.op[1];
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              dz_d    = (bus.b == '0);
              m_d     = bus.op[1] ? b_mag : a_mag;
              acch_d  = '0;
              accl_d  = bus.op[1] ? a_mag : b_mag;
            end
            (bus.op == 3'b100): hi_d = bus.a;
            (bus.op == 3'b101): lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acch_d = it_hi;
          accl_d = it_lo;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_DONE;
            if (!isdiv_q) begin
              {hi_d, lo_d} = prod_f;
            end else if (!dz_q) begin
              hi_d = rem;
              lo_d = quo;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      isdiv_q <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      m_q     <= '0;
      acch_q  <= '0;
      accl_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isdiv_q <= isdiv_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      m_q     <= m_d;
      acch_q  <= acch_d;
      accl_q  <= accl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.stall = (bus.start & is_md
                     & (state_q == S_IDLE)
                     & ~bus.flush)
                   | (state_q == S_BUSY);
  assign bus.busy  = (state_q == S_BUSY);
  assign bus.done  = (state_q == S_DONE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: mul/div results, latency,
// HI/LO moves, divide by zero, flush and reset.
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(
    input logic [2:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(
    output int nbusy,
    output bit got
  );
    nbusy = 0;
    got   = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy) nbusy++;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.hi !== 0 || bus.lo !== 0) begin
      errors++;
      $display("FAIL reset_hilo: got %h/%h want 0/0",
               bus.hi, bus.lo);
    end
    checks++;
    if (bus.busy !== 0 || bus.done !== 0
        || bus.stall !== 0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b done=%b stall=%b want 0",
               bus.busy, bus.done, bus.stall);
    end
  endtask

  task automatic test_mult();
    int nb;
    bit got;
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 32'hFFFF_FFFD;
    bus.b     = 32'd5;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL mult_stall_req: got %b want 1", bus.stall);
    end
    start_op(3'b000, 32'hFFFF_FFFD, 32'd5);
    wait_done(nb, got);
    checks++;
    if (!got || nb != 32) begin
      errors++;
      $display("FAIL mult_latency: done=%b busy_cycles=%0d want 1/32",
               got, nb);
    end
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF
        || bus.lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_neg: got %h_%h want ffffffff_fffffff1",
               bus.hi, bus.lo);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL done_stall: got %b want 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got %b want 0", bus.done);
    end
  endtask

  task automatic test_mult_ext();
    int nb;
    bit got;
    start_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb, got);
    checks++;
    if (!got || bus.hi !== 32'hFFFF_FFFE
        || bus.lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_max: got %h_%h want fffffffe_00000001",
               bus.hi, bus.lo);
    end
    tick();
    start_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb, got);
    checks++;
    if (!got || bus.hi !== 0 || bus.lo !== 1) begin
      errors++;
      $display("FAIL mult_m1m1: got %h_%h want 0_1",
               bus.hi, bus.lo);
    end
    tick();
  endtask

  task automatic test_div();
    int nb;
    bit got;
    start_op(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done(nb, got);
    checks++;
    if (!got || bus.lo !== 32'hFFFF_FFFD
        || bus.hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_neg: got q=%h r=%h want fffffffd/ffffffff",
               bus.lo, bus.hi);
    end
    tick();
    start_op(3'b011, 32'd100, 32'd7);
    wait_done(nb, got);
    checks++;
    if (!got || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      errors++;
      $display("FAIL divu: got q=%0d r=%0d want 14/2",
               bus.lo, bus.hi);
    end
    tick();
    start_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(nb, got);
    checks++;
    if (!got || bus.lo !== 32'h8000_0000 || bus.hi !== 0) begin
      errors++;
      $display("FAIL div_ovf: got q=%h r=%h want 80000000/0",
               bus.lo, bus.hi);
    end
    tick();
  endtask

  task automatic test_mthi_div0();
    int nb;
    bit got;
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'h1234;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL mthi_stall: got %b want 0", bus.stall);
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.hi !== 32'h1234 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h busy=%b want 1234/0",
               bus.hi, bus.busy);
    end
    start_op(3'b011, 32'd5, 32'd0);
    wait_done(nb, got);
    checks++;
    if (!got || nb != 32) begin
      errors++;
      $display("FAIL div0_latency: done=%b busy_cycles=%0d want 1/32",
               got, nb);
    end
    checks++;
    if (bus.hi !== 32'h1234 || bus.lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div0_keep: got %h/%h want 1234/80000000",
               bus.hi, bus.lo);
    end
    tick();
  endtask

  task automatic test_flush();
    bit seen;
    start_op(3'b100, 32'hAAAA, 32'd0);
    start_op(3'b101, 32'h5555, 32'd0);
    start_op(3'b000, 32'd3, 32'd4);
    for (int i = 0; i < 10; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b stall=%b want 0/0",
               bus.busy, bus.stall);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_done: got done=1 want no pulse");
    end
    checks++;
    if (bus.hi !== 32'hAAAA || bus.lo !== 32'h5555) begin
      errors++;
      $display("FAIL flush_keep: got %h/%h want aaaa/5555",
               bus.hi, bus.lo);
    end
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 32'd2;
    bus.b     = 32'd2;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_stall: got %b want 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start: busy=%b want 0", bus.busy);
    end
    bus.op = 3'b100;
    bus.a  = 32'hDEAD;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.hi !== 32'hAAAA) begin
      errors++;
      $display("FAIL flush_mthi: hi=%h want aaaa", bus.hi);
    end
  endtask

  task automatic test_busy_rst();
    start_op(3'b000, 32'd2, 32'd3);
    start_op(3'b101, 32'hBEEF, 32'd0);
    checks++;
    if (bus.lo !== 32'h5555 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mtlo: lo=%h busy=%b want 5555/1",
               bus.lo, bus.busy);
    end
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.hi !== 0 || bus.lo !== 0 || bus.busy !== 0
        || bus.done !== 0) begin
      errors++;
      $display("FAIL mid_rst: hi=%h lo=%h busy=%b done=%b want 0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    bit got;
    start_op(3'b001, 32'd6, 32'd7);
    wait_done(nb, got);
    checks++;
    if (!got || bus.lo !== 32'd42 || bus.hi !== 0) begin
      errors++;
      $display("FAIL b2b_mul: got %h_%h want 0_2a",
               bus.hi, bus.lo);
    end
    bus.start = 1'b1;
    bus.op    = 3'b011;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_ign: busy=%b stall=%b want 0/1",
               bus.busy, bus.stall);
    end
    tick();
    bus.start = 1'b0;
    wait_done(nb, got);
    checks++;
    if (!got || nb != 32 || bus.lo !== 32'd10
        || bus.hi !== 0) begin
      errors++;
      $display("FAIL b2b_div: cyc=%0d q=%0d r=%0d want 32/10/0",
               nb, bus.lo, bus.hi);
    end
    tick();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b111;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    test_reset();
    test_mult();
    test_mult_ext();
    test_div();
    test_mthi_div0();
    test_flush();
    test_busy_rst();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
